// File: rtl/crossbar_oport_pkg.sv
// Shared NoC sizing defines plus small helpers for the crossbar output port.
// The defines are guarded so that any other NoC file can carry the same set.
`ifndef NOC_DEFINES_SVH
`define NOC_DEFINES_SVH
`define DW        32
`define V         4
`define BUF_DEPTH 4
`endif

package crossbar_oport_pkg;

  // True when exactly one bit of a VC select vector is set.
  function automatic logic isOneHot(input logic [`V-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/crossbar_oport_credit_counter.sv
// Per-VC downstream credit counter: range 0..DEPTH, saturating at DEPTH.
// A simultaneous dec and inc cancel; ovf flags a credit return while full.
module credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          ovf
);

  logic [CW-1:0] r_count;
  logic          w_full;

  assign w_full  = (r_count == CW'(DEPTH));
  assign count   = r_count;
  assign nonzero = (r_count != '0);
  assign ovf     = inc && !dec && w_full;

  // dec is only ever asserted by the port when the count is nonzero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= CW'(DEPTH);
    end else if (dec && !inc) begin
      r_count <= r_count - CW'(1);
    end else if (inc && !dec && !w_full) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/crossbar_oport.sv
// Crossbar output port: registers granted flits onto the link and tracks
// downstream per-VC credits, dropping and flagging flits that cannot be sent.
module crossbar_oport
  import crossbar_oport_pkg::*;
#(
  parameter int DW    = `DW,
  parameter int V     = `V,
  parameter int DEPTH = `BUF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  input  logic [V-1:0]  vc_sel,
  input  logic [V-1:0]  credit_in,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic [1:0]    vc_id_out,
  output logic [V-1:0]  credit_avail,
  output logic          err
);

  logic [DW-1:0]        r_data;
  logic                 r_valid;
  logic [1:0]           r_vcId;
  logic                 r_err;

  logic                 w_oneHot;
  logic                 w_accept;
  logic                 w_drop;
  logic [1:0]           w_enc;
  logic [V-1:0]         w_dec;
  logic [V-1:0]         w_nonzero;
  logic [V-1:0]         w_ovf;
  logic [V-1:0][CW-1:0] w_count;

  assign w_oneHot = isOneHot(vc_sel);
  assign w_accept = valid_in && w_oneHot && ((vc_sel & w_nonzero) != '0);
  assign w_drop   = valid_in && !w_accept;
  assign w_dec    = w_accept ? vc_sel : '0;

  always_comb begin
    w_enc = 2'd0;
    for (int i = 0; i < V; i++) begin
      if (vc_sel[i]) begin
        w_enc = 2'(i);
      end
    end
  end

  for (genvar g = 0; g < V; g++) begin : g_vc
    credit_counter #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .dec     (w_dec[g]),
      .inc     (credit_in[g]),
      .count   (w_count[g]),
      .nonzero (w_nonzero[g]),
      .ovf     (w_ovf[g])
    );
  end

  // Dropped flits and credit overflows both latch err until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_vcId  <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      r_data  <= data_in;
      r_valid <= w_accept;
      r_vcId  <= w_enc;
      r_err   <= r_err || w_drop || (w_ovf != '0);
    end
  end

  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign vc_id_out    = r_vcId;
  assign err          = r_err;
  assign credit_avail = w_nonzero;

endmodule

// File: tb/tb_crossbar_oport.sv
// Directed bench for crossbar_oport: link registering, credit accounting,
// drop/overflow error flagging and mid-operation reset.
module tb_crossbar_oport;

  logic        clk;
  logic        rstn;
  logic [31:0] data_in;
  logic        valid_in;
  logic [3:0]  vc_sel;
  logic [3:0]  credit_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  vc_id_out;
  logic [3:0]  credit_avail;
  logic        err;

  int checkCount;
  int passCount;

  crossbar_oport dut (
    .clk          (clk),
    .rstn         (rstn),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .vc_sel       (vc_sel),
    .credit_in    (credit_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .vc_id_out    (vc_id_out),
    .credit_avail (credit_avail),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] sel,
                               input logic [31:0] d, input logic [3:0] cr);
    valid_in  = v;
    vc_sel    = sel;
    data_in   = d;
    credit_in = cr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendFlits(input logic [3:0] sel, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, sel, 32'h100 + i, 4'b0000);
      tick();
    end
    applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
  endtask

  task automatic checkCounts(input string tag, input logic [2:0] c0, input logic [2:0] c1,
                             input logic [2:0] c2, input logic [2:0] c3);
    checkOutput({tag, "_cnt0"}, 32'(dut.w_count[0]), 32'(c0));
    checkOutput({tag, "_cnt1"}, 32'(dut.w_count[1]), 32'(c1));
    checkOutput({tag, "_cnt2"}, 32'(dut.w_count[2]), 32'(c2));
    checkOutput({tag, "_cnt3"}, 32'(dut.w_count[3]), 32'(c3));
  endtask

  task automatic doReset(input string tag);
    rstn = 1'b0;
    #2;
    checkOutput({tag, "_avail"}, 32'(credit_avail), 32'h0000_000F);
    checkOutput({tag, "_valid"}, 32'(valid_out), 32'h0);
    checkOutput({tag, "_err"}, 32'(err), 32'h0);
    checkOutput({tag, "_data"}, data_out, 32'h0);
    checkOutput({tag, "_vcid"}, 32'(vc_id_out), 32'h0);
    checkCounts(tag, 3'd4, 3'd4, 3'd4, 3'd4);
    applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
    rstn = 1'b1;
    #3;
    doReset("rst");
    checkOutput("rst_rel_avail", 32'(credit_avail), 32'h0000_000F);
    checkOutput("rst_rel_err", 32'(err), 32'h0);

    // Basic send to VC2
    applyStimulus(1'b1, 4'b0100, 32'hA5A5_0001, 4'b0000);
    tick();
    checkOutput("send_data", data_out, 32'hA5A5_0001);
    checkOutput("send_valid", 32'(valid_out), 32'h1);
    checkOutput("send_vcid", 32'(vc_id_out), 32'h2);
    checkCounts("send", 3'd4, 3'd4, 3'd3, 3'd4);

    // valid_in low: vc_sel ignored, nothing forwarded
    applyStimulus(1'b0, 4'b0001, 32'hDEAD_BEEF, 4'b0000);
    tick();
    checkOutput("idle_valid", 32'(valid_out), 32'h0);
    checkCounts("idle", 3'd4, 3'd4, 3'd3, 3'd4);

    // Exhaust VC1
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0010, 32'h1000 + i, 4'b0000);
      tick();
      checkOutput("exh_valid", 32'(valid_out), 32'h1);
      checkOutput("exh_vcid", 32'(vc_id_out), 32'h1);
    end
    checkOutput("exh_avail", 32'(credit_avail), 32'h0000_000D);
    checkOutput("exh_err_pre", 32'(err), 32'h0);
    applyStimulus(1'b1, 4'b0010, 32'h1004, 4'b0000);
    tick();
    checkOutput("exh5_valid", 32'(valid_out), 32'h0);
    checkOutput("exh5_err", 32'(err), 32'h1);
    checkOutput("exh5_cnt1", 32'(dut.w_count[1]), 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
    tick();
    checkOutput("exh_err_sticky", 32'(err), 32'h1);

    // Simultaneous accept and credit on VC0
    doReset("rst2");
    sendFlits(4'b0001, 2);
    checkOutput("sim_pre_cnt0", 32'(dut.w_count[0]), 32'h2);
    applyStimulus(1'b1, 4'b0001, 32'hCAFE_0000, 4'b0001);
    tick();
    checkOutput("sim_valid", 32'(valid_out), 32'h1);
    checkOutput("sim_data", data_out, 32'hCAFE_0000);
    checkOutput("sim_cnt0", 32'(dut.w_count[0]), 32'h2);
    checkOutput("sim_err", 32'(err), 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0001);
    tick();
    checkOutput("ret_cnt0", 32'(dut.w_count[0]), 32'h3);

    // Credit overflow on VC3
    applyStimulus(1'b0, 4'b0000, 32'h0, 4'b1000);
    tick();
    checkOutput("ovf_cnt3", 32'(dut.w_count[3]), 32'h4);
    checkOutput("ovf_err", 32'(err), 32'h1);

    // Non-one-hot and zero vc_sel are dropped
    doReset("rst3");
    applyStimulus(1'b1, 4'b0011, 32'h5555_0000, 4'b0000);
    tick();
    checkOutput("bad_valid", 32'(valid_out), 32'h0);
    checkOutput("bad_err", 32'(err), 32'h1);
    checkCounts("bad", 3'd4, 3'd4, 3'd4, 3'd4);
    doReset("rst4");
    applyStimulus(1'b1, 4'b0000, 32'h5555_0001, 4'b0000);
    tick();
    checkOutput("zero_valid", 32'(valid_out), 32'h0);
    checkOutput("zero_err", 32'(err), 32'h1);

    // Build counters 1,0,2,3 then test independent multi-VC updates
    doReset("rst5");
    sendFlits(4'b0001, 3);
    sendFlits(4'b0010, 4);
    sendFlits(4'b0100, 2);
    sendFlits(4'b1000, 1);
    checkCounts("mid", 3'd1, 3'd0, 3'd2, 3'd3);
    checkOutput("mid_avail", 32'(credit_avail), 32'h0000_000D);
    applyStimulus(1'b1, 4'b0001, 32'h7777_0000, 4'b0110);
    tick();
    checkOutput("multi_valid", 32'(valid_out), 32'h1);
    checkCounts("multi", 3'd0, 3'd1, 3'd3, 3'd3);
    checkOutput("multi_avail", 32'(credit_avail), 32'h0000_000E);
    checkOutput("multi_err", 32'(err), 32'h0);

    // Mid-operation reset with a flit in flight
    applyStimulus(1'b1, 4'b0100, 32'h9999_0000, 4'b0000);
    #2;
    doReset("midrst");
    checkOutput("post_valid", 32'(valid_out), 32'h0);
    checkCounts("post", 3'd4, 3'd4, 3'd4, 3'd4);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
